// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter funnelling N single-beat requesters onto one 64-bit AXI4 master port.
// Define AXI_ARB_PERF_EN to add per-requester grant and wait counters (perf_grants, perf_wait).
module axi_rr_arbiter #(
  parameter int N_MST  = 2,
  parameter int ADDR_W = 32,
  parameter int PERF_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MST-1:0]        req_valid,
  input  logic [N_MST-1:0]        req_write,
  input  logic [N_MST*ADDR_W-1:0] req_addr,
  input  logic [N_MST*2-1:0]      req_size,
  input  logic [N_MST*32-1:0]     req_wdata,
  output logic [N_MST-1:0]        resp_valid,
  output logic [31:0]             resp_rdata,
  output logic                    resp_err,
  output logic [ADDR_W-1:0]       m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [3:0]              m_arid,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  input  logic [63:0]             m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic [3:0]              m_rid,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic [ADDR_W-1:0]       m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [3:0]              m_awid,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic [63:0]             m_wdata,
  output logic [7:0]              m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic [3:0]              m_bid,
  input  logic                    m_bvalid,
  output logic                    m_bready
`ifdef AXI_ARB_PERF_EN
  ,
  output logic [N_MST*PERF_W-1:0] perf_grants,
  output logic [N_MST*PERF_W-1:0] perf_wait
`endif
);

  localparam int IDX_W = (N_MST > 1) ? $clog2(N_MST) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_WR, ST_B, ST_RESP} state_t;

  state_t              state, state_nx;
  logic [IDX_W-1:0]    rr_ptr, pick, idx_hi, idx_lo, grant_p0;
  logic                found_hi, found_lo, found, pick_write;
  logic [ADDR_W-1:0]   pick_addr, addr_p0;
  logic [1:0]          pick_size, size_p0;
  logic [31:0]         pick_wdata, wdata_p0;
  logic                aw_done, w_done, aw_fire, w_fire;
  logic                unused_ok;

  function automatic logic [31:0] rd_lane(input logic [63:0] d, input logic [2:0] a,
                                          input logic [1:0] s);
    logic [31:0] w;
    w = a[2] ? d[63:32] : d[31:0];
    w = w >> {a[1:0], 3'b000};
    case (s)
      2'd0:    rd_lane = {24'h0, w[7:0]};
      2'd1:    rd_lane = {16'h0, w[15:0]};
      default: rd_lane = w;
    endcase
  endfunction

  // Lanes beyond the 4-byte word are dropped by the shift: crossing accesses are unsupported.
  function automatic logic [7:0] wr_strb(input logic [2:0] a, input logic [1:0] s);
    logic [3:0] s4;
    case (s)
      2'd0:    s4 = 4'h1;
      2'd1:    s4 = 4'h3;
      default: s4 = 4'hF;
    endcase
    s4 = s4 << a[1:0];
    wr_strb = a[2] ? {s4, 4'h0} : {4'h0, s4};
  endfunction

  function automatic logic [63:0] wr_data(input logic [31:0] d, input logic [1:0] a);
    logic [31:0] w;
    w = d << {a, 3'b000};
    wr_data = {w, w};
  endfunction

  // Stage p0: round-robin pick; first set bit at or above rr_ptr, else lowest set bit
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = N_MST - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found_lo = 1'b1;
        idx_lo   = IDX_W'(i);
        if (i >= int'(rr_ptr)) begin
          found_hi = 1'b1;
          idx_hi   = IDX_W'(i);
        end
      end
    end
    found      = found_lo;
    pick       = found_hi ? idx_hi : idx_lo;
    pick_write = 1'b0;
    pick_addr  = '0;
    pick_size  = '0;
    pick_wdata = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (int'(pick) == i) begin
        pick_write = req_write[i];
        pick_addr  = req_addr[i*ADDR_W +: ADDR_W];
        pick_size  = req_size[2*i +: 2];
        pick_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && found) begin
      grant_p0 <= pick;
      addr_p0  <= pick_addr;
      size_p0  <= pick_size;
      wdata_p0 <= pick_wdata;
    end
  end

  assign aw_fire = m_awvalid && m_awready;
  assign w_fire  = m_wvalid && m_wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        ST_WR: begin
          if (aw_fire) aw_done <= 1'b1;
          if (w_fire)  w_done  <= 1'b1;
        end
        ST_R: if (m_rvalid) begin
          resp_rdata <= rd_lane(m_rdata, addr_p0[2:0], size_p0);
          resp_err   <= |m_rresp;
        end
        ST_B: if (m_bvalid) resp_err <= |m_bresp;
        ST_RESP: rr_ptr <= (int'(grant_p0) == N_MST - 1) ? '0 : grant_p0 + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx   = state;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    resp_valid = '0;
    case (state)
      ST_IDLE: if (found) state_nx = pick_write ? ST_WR : ST_AR;
      ST_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_nx = ST_R;
      end
      ST_R: begin
        m_rready = 1'b1;
        if (m_rvalid) state_nx = ST_RESP;
      end
      ST_WR: begin
        m_awvalid = !aw_done;
        m_wvalid  = !w_done;
        if ((aw_done || m_awready) && (w_done || m_wready)) state_nx = ST_B;
      end
      ST_B: begin
        m_bready = 1'b1;
        if (m_bvalid) state_nx = ST_RESP;
      end
      ST_RESP: begin
        for (int i = 0; i < N_MST; i++) resp_valid[i] = (int'(grant_p0) == i);
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign m_araddr  = addr_p0;
  assign m_awaddr  = addr_p0;
  assign m_arsize  = {1'b0, size_p0};
  assign m_awsize  = {1'b0, size_p0};
  assign m_arid    = 4'(grant_p0);
  assign m_awid    = 4'(grant_p0);
  assign m_arlen   = 8'h00;
  assign m_awlen   = 8'h00;
  assign m_arburst = 2'b01;
  assign m_awburst = 2'b01;
  assign m_wlast   = 1'b1;
  assign m_wstrb   = wr_strb(addr_p0[2:0], size_p0);
  assign m_wdata   = wr_data(wdata_p0, addr_p0[1:0]);
  assign unused_ok = ^{m_rlast, m_rid, m_bid};

`ifdef AXI_ARB_PERF_EN
  logic [PERF_W-1:0] grants_cnt [N_MST];
  logic [PERF_W-1:0] wait_cnt   [N_MST];

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_MST; i++) begin
      if (rst) begin
        grants_cnt[i] <= '0;
        wait_cnt[i]   <= '0;
      end else begin
        if (state == ST_RESP && int'(grant_p0) == i && !(&grants_cnt[i]))
          grants_cnt[i] <= grants_cnt[i] + 1'b1;
        if (req_valid[i] && !(state != ST_IDLE && int'(grant_p0) == i) && !(&wait_cnt[i]))
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_MST; i++) begin
      perf_grants[i*PERF_W +: PERF_W] = grants_cnt[i];
      perf_wait[i*PERF_W +: PERF_W]   = wait_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Bench for axi_rr_arbiter: behavioural AXI slave, per-master request counters, response scoreboard.
module tb_axi_rr_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_write, resp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*2-1:0]  req_size;
  logic [N*32-1:0] req_wdata;
  logic [31:0]     resp_rdata;
  logic            resp_err;
  logic [AW-1:0]   m_araddr, m_awaddr;
  logic            m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, m_wlast;
  logic [3:0]      m_arid, m_awid;
  logic [7:0]      m_arlen, m_awlen, m_wstrb;
  logic [2:0]      m_arsize, m_awsize;
  logic [1:0]      m_arburst, m_awburst;
  logic [63:0]     m_wdata;
  logic            m_arready = 0, m_awready = 0, m_wready = 0, m_rvalid = 0, m_bvalid = 0;
  logic            m_rlast = 0;
  logic [63:0]     m_rdata = 0;
  logic [1:0]      m_rresp = 0, m_bresp = 0;
  logic [3:0]      m_rid = 0, m_bid = 0;
`ifdef AXI_ARB_PERF_EN
  logic [N*32-1:0] perf_grants, perf_wait;
`endif

  axi_rr_arbiter #(.N_MST(N), .ADDR_W(AW), .PERF_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bid(m_bid), .m_bvalid(m_bvalid), .m_bready(m_bready)
`ifdef AXI_ARB_PERF_EN
    , .perf_grants(perf_grants), .perf_wait(perf_wait)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Requester side: master i holds req_valid while it has more requests issued than completed
  int          issued [N] = '{default: 0};
  int          done   [N] = '{default: 0};
  logic        cfg_write [N] = '{default: 1'b0};
  logic [31:0] cfg_addr  [N] = '{default: 32'h0};
  logic [1:0]  cfg_size  [N] = '{default: 2'd0};
  logic [31:0] cfg_wdata [N] = '{default: 32'h0};

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = (issued[i] != done[i]);
      req_write[i]          = cfg_write[i];
      req_addr[i*AW +: AW]  = cfg_addr[i];
      req_size[2*i +: 2]    = cfg_size[i];
      req_wdata[32*i +: 32] = cfg_wdata[i];
    end
  end

  typedef struct {
    logic [N-1:0] vec;
    bit           wr;
    logic [31:0]  rdata;
    bit           err;
  } txn_t;
  txn_t exp_q[$];
  txn_t obs_q[$];

  always @(negedge clk) begin
    txn_t o;
    if (!rst && resp_valid != '0) begin
      o.vec = resp_valid; o.wr = 1'b0; o.rdata = resp_rdata; o.err = resp_err;
      obs_q.push_back(o);
      for (int i = 0; i < N; i++) if (resp_valid[i]) done[i]++;
    end
  end

  // Behavioural slave: programmable handshake latencies, captures what it was sent
  int          ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0;
  int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0;
  bit          r_pend = 0, aw_got = 0, w_got = 0;
  logic [63:0] rdata_cfg = 64'h1122_3344_5566_7788;
  logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
  logic [31:0] cap_araddr = 0, cap_awaddr = 0;
  logic [2:0]  cap_arsize = 0;
  logic [3:0]  cap_arid = 0, cap_awid = 0;
  logic [7:0]  cap_arlen = 0, cap_wstrb = 0;
  logic [1:0]  cap_arburst = 0;
  logic [63:0] cap_wdata = 0;
  logic        cap_wlast = 0;
  int          wv_viol = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
      r_pend = 0; aw_got = 0; w_got = 0; ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
    end else begin
      if (w_got && m_wvalid) wv_viol++;
      m_arready = 0;
      if (m_arvalid && !r_pend) begin
        if (ar_cnt >= ar_lat) begin
          m_arready = 1; ar_cnt = 0; r_pend = 1; r_cnt = 0;
          cap_araddr = m_araddr; cap_arsize = m_arsize; cap_arid = m_arid;
          cap_arlen = m_arlen; cap_arburst = m_arburst;
        end else ar_cnt++;
      end
      m_rvalid = 0;
      if (r_pend && m_rready) begin
        if (r_cnt >= r_lat) begin
          m_rvalid = 1; m_rdata = rdata_cfg; m_rresp = rresp_cfg; m_rid = cap_arid;
          m_rlast = 1; r_pend = 0;
        end else r_cnt++;
      end
      m_awready = 0;
      if (m_awvalid && !aw_got) begin
        if (aw_cnt >= aw_lat) begin
          m_awready = 1; aw_got = 1; aw_cnt = 0; cap_awid = m_awid; cap_awaddr = m_awaddr;
        end else aw_cnt++;
      end
      m_wready = 0;
      if (m_wvalid && !w_got) begin
        if (w_cnt >= w_lat) begin
          m_wready = 1; w_got = 1; w_cnt = 0;
          cap_wdata = m_wdata; cap_wstrb = m_wstrb; cap_wlast = m_wlast;
        end else w_cnt++;
      end
      m_bvalid = 0;
      if (aw_got && w_got && m_bready) begin
        m_bvalid = 1; m_bresp = bresp_cfg; m_bid = cap_awid; aw_got = 0; w_got = 0;
      end
    end
  end

  task automatic issue(input int idx, input bit wr, input logic [31:0] a, input logic [1:0] s,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err);
    txn_t e;
    cfg_write[idx] = wr; cfg_addr[idx] = a; cfg_size[idx] = s; cfg_wdata[idx] = wd;
    e.vec = '0; e.vec[idx] = 1'b1; e.wr = wr; e.rdata = exp_rd; e.err = exp_err;
    exp_q.push_back(e);
    issued[idx]++;
  endtask

  task automatic wait_quiet(input string tag);
    int n;
    bit busy;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      busy = 0;
      for (int i = 0; i < N; i++) if (issued[i] != done[i]) busy = 1;
    end while (busy && n < 300);
    if (busy) begin
      checks++; errors++;
      $display("FAIL %s_timeout: requests still pending after %0d cycles, required all complete", tag, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, resp_valid, resp_err} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: ar/aw/w valid,rready,bready,resp_valid,err = %b, required 0",
               {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, resp_valid, resp_err});
    end
    checks++;
    if (resp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h, required 00000000", resp_rdata);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load();
    int cyc;
    rdata_cfg = 64'h1122_3344_5566_7788;
    issue(0, 1'b0, 32'h8000_0004, 2'd2, 32'h0, 32'h1122_3344, 1'b0);
    cyc = 0;
    while (cyc < 20 && !resp_valid[0]) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 3) begin errors++; $display("FAIL load_latency: got %0d cycles, required 3", cyc); end
    checks++;
    if (cap_araddr !== 32'h8000_0004) begin
      errors++; $display("FAIL load_araddr: got %h, required 80000004", cap_araddr);
    end
    checks++;
    if ({cap_arsize, cap_arid} !== {3'd2, 4'd0}) begin
      errors++; $display("FAIL load_arsize_id: got size %0d id %0d, required size 2 id 0", cap_arsize, cap_arid);
    end
    checks++;
    if ({cap_arlen, cap_arburst} !== {8'h00, 2'b01}) begin
      errors++; $display("FAIL load_len_burst: got len %h burst %b, required 00/01", cap_arlen, cap_arburst);
    end
    wait_quiet("load");
  endtask

  task automatic test_store();
    issue(1, 1'b1, 32'h8000_0002, 2'd1, 32'h0000_ABCD, 32'h0, 1'b0);
    wait_quiet("store");
    checks++;
    if (cap_wstrb !== 8'h0C) begin errors++; $display("FAIL store_wstrb: got %h, required 0c", cap_wstrb); end
    checks++;
    if (cap_wdata !== 64'hABCD_0000_ABCD_0000) begin
      errors++; $display("FAIL store_wdata: got %h, required abcd0000abcd0000", cap_wdata);
    end
    checks++;
    if ({cap_awid, cap_wlast} !== {4'd1, 1'b1}) begin
      errors++; $display("FAIL store_awid_wlast: got id %0d wlast %b, required id 1 wlast 1", cap_awid, cap_wlast);
    end
    checks++;
    if (cap_awaddr !== 32'h8000_0002) begin
      errors++; $display("FAIL store_awaddr: got %h, required 80000002", cap_awaddr);
    end
  endtask

  task automatic test_back_to_back();
`ifdef AXI_ARB_PERF_EN
    logic [31:0] g0, g1;
    g0 = perf_grants[31:0];
    g1 = perf_grants[63:32];
`endif
    for (int k = 0; k < 5; k++) begin
      issue(0, 1'b0, 32'h8000_0101, 2'd0, 32'h0, 32'h0000_0077, 1'b0);
      issue(1, 1'b0, 32'h8000_0206, 2'd1, 32'h0, 32'h0000_1122, 1'b0);
    end
    wait_quiet("back_to_back");
`ifdef AXI_ARB_PERF_EN
    checks++;
    if ((perf_grants[31:0] - g0) !== 32'd5 || (perf_grants[63:32] - g1) !== 32'd5) begin
      errors++;
      $display("FAIL perf_grants: got deltas %0d/%0d, required 5/5",
               perf_grants[31:0] - g0, perf_grants[63:32] - g1);
    end
`endif
  endtask

  task automatic test_w_before_aw();
    int d0;
    d0 = done[0];
    aw_lat = 3; w_lat = 0; wv_viol = 0;
    issue(0, 1'b1, 32'h8000_0010, 2'd2, 32'hDEAD_BEEF, 32'h0, 1'b0);
    wait_quiet("w_before_aw");
    aw_lat = 0;
    checks++;
    if (wv_viol != 0) begin errors++; $display("FAIL wvalid_drop: wvalid high %0d cycles after handshake, required 0", wv_viol); end
    checks++;
    if (done[0] - d0 != 1) begin errors++; $display("FAIL w_first_resp_count: got %0d responses, required 1", done[0] - d0); end
    checks++;
    if ({cap_wstrb, cap_wdata} !== {8'h0F, 64'hDEAD_BEEF_DEAD_BEEF}) begin
      errors++; $display("FAIL w_first_lanes: got strb %h data %h, required 0f deadbeefdeadbeef", cap_wstrb, cap_wdata);
    end
  endtask

  task automatic test_error();
    bresp_cfg = 2'b10;
    issue(1, 1'b1, 32'h8000_0008, 2'd2, 32'h1234_5678, 32'h0, 1'b1);
    wait_quiet("error_store");
    bresp_cfg = 2'b00;
    checks++;
    if (resp_rdata !== 32'h0000_1122) begin
      errors++; $display("FAIL rdata_hold: got %h, required 00001122", resp_rdata);
    end
    issue(0, 1'b0, 32'h8000_0000, 2'd2, 32'h0, 32'h5566_7788, 1'b0);
    wait_quiet("error_load");
  endtask

  task automatic test_reset_mid();
    int n;
    issue(0, 1'b0, 32'h8000_0000, 2'd2, 32'h0, 32'h5566_7788, 1'b0);
    wait_quiet("pre_reset");
    r_lat = 10;
    cfg_write[1] = 1'b0; cfg_addr[1] = 32'h8000_0004; cfg_size[1] = 2'd2;
    issued[1]++;
    n = 0;
    while (n < 20 && !m_rready) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!m_rready) begin errors++; $display("FAIL reach_r_state: rready %b, required 1", m_rready); end
    rst = 1'b1;
    issued[1] = done[1];
    r_lat = 0;
    @(negedge clk);
    checks++;
    if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, resp_valid} !== '0) begin
      errors++;
      $display("FAIL mid_reset_valids: got %b, required 0",
               {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, resp_valid});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(0, 1'b0, 32'h8000_0000, 2'd2, 32'h0, 32'h5566_7788, 1'b0);
    issue(1, 1'b0, 32'h8000_0004, 2'd2, 32'h0, 32'h1122_3344, 1'b0);
    wait_quiet("post_reset");
  endtask

  task automatic test_scoreboard();
    txn_t e, o;
    int k;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL sb_count: got %0d responses, required %0d", obs_q.size(), exp_q.size());
    end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.vec !== e.vec) begin
        errors++; $display("FAIL sb_grant[%0d]: resp_valid %b, required %b", k, o.vec, e.vec);
      end
      checks++;
      if (o.err !== e.err) begin
        errors++; $display("FAIL sb_err[%0d]: resp_err %b, required %b", k, o.err, e.err);
      end
      if (!e.wr) begin
        checks++;
        if (o.rdata !== e.rdata) begin
          errors++; $display("FAIL sb_rdata[%0d]: resp_rdata %h, required %h", k, o.rdata, e.rdata);
        end
      end
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_w_before_aw();
    test_error();
    test_reset_mid();
    test_scoreboard();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
